// File: rtl/prime_checker_seq_if.sv
// Number-in / verdict-out handshake bundle for prime_checker_seq.
// res_factor exists only when PRIME_FACTOR_OUT_EN is defined.
interface prime_checker_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_num;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_num;
  logic             res_is_prime;
`ifdef PRIME_FACTOR_OUT_EN
  logic [WIDTH-1:0] res_factor;

  modport master (
    output in_valid, in_num, res_ready,
    input  in_ready, res_valid, res_num, res_is_prime, res_factor
  );
  modport slave (
    input  in_valid, in_num, res_ready,
    output in_ready, res_valid, res_num, res_is_prime, res_factor
  );
`else
  modport master (
    output in_valid, in_num, res_ready,
    input  in_ready, res_valid, res_num, res_is_prime
  );
  modport slave (
    input  in_valid, in_num, res_ready,
    output in_ready, res_valid, res_num, res_is_prime
  );
`endif
endinterface

// File: rtl/prime_checker_seq.sv
// Sequential trial-division primality checker: divisor 2 then odd divisors, one per clock, up to sqrt(n).
// Optional feature macro: PRIME_FACTOR_OUT_EN adds the smallest-factor result register.
module prime_checker_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  prime_checker_seq_if.slave bus,
  output logic               busy
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             prime_q, prime_d;
`ifdef PRIME_FACTOR_OUT_EN
  logic [WIDTH-1:0] factor_q, factor_d;
`endif

  logic [W2-1:0]    div_sq;
  logic [WIDTH-1:0] rem;

  // Squaring at double width keeps the d*d > n test exact for every WIDTH.
  assign div_sq = W2'(div_q) * W2'(div_q);
  assign rem    = (div_q == '0) ? '0 : (num_q % div_q);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      num_q    <= '0;
      prime_q  <= 1'b0;
`ifdef PRIME_FACTOR_OUT_EN
      factor_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      num_q    <= num_d;
      prime_q  <= prime_d;
`ifdef PRIME_FACTOR_OUT_EN
      factor_q <= factor_d;
`endif
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through this block can infer a latch.
    state_d  = state_q;
    div_d    = div_q;
    num_d    = num_q;
    prime_d  = prime_q;
`ifdef PRIME_FACTOR_OUT_EN
    factor_d = factor_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          num_d = bus.in_num;
          if (bus.in_num <= WIDTH'(1)) begin
            prime_d  = 1'b0;
`ifdef PRIME_FACTOR_OUT_EN
            factor_d = '0;
`endif
            state_d  = DONE;
          end else begin
            div_d   = WIDTH'(2);
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (div_sq > W2'(num_q)) begin
          prime_d  = 1'b1;
`ifdef PRIME_FACTOR_OUT_EN
          factor_d = num_q;
`endif
          state_d  = DONE;
        end else if (rem == '0) begin
          prime_d  = 1'b0;
`ifdef PRIME_FACTOR_OUT_EN
          factor_d = div_q;
`endif
          state_d  = DONE;
        end else begin
          div_d = (div_q == WIDTH'(2)) ? WIDTH'(3) : div_q + WIDTH'(2);
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.res_valid = (state_q == DONE);
    busy          = (state_q == CHECK);
  end

  assign bus.res_num      = num_q;
  assign bus.res_is_prime = prime_q;
`ifdef PRIME_FACTOR_OUT_EN
  assign bus.res_factor   = factor_q;
`endif

endmodule

// File: tb/tb_prime_checker_seq.sv
// Directed bench for prime_checker_seq: a WIDTH=32 and a WIDTH=8 instance driven in lockstep.
// Latency L counts edges from the accept edge (cycle 0) to the first sample with res_valid high.
module tb_prime_checker_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prime_checker_seq_if #(.WIDTH(32)) if32 ();
  prime_checker_seq_if #(.WIDTH(8))  if8 ();
  logic busy32, busy8;

  prime_checker_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave), .busy(busy32));
  prime_checker_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave),  .busy(busy8));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] num;
    logic       prime;
    logic [7:0] factor;
    int         lat;
    bit         hold;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [7:0] n);
    if32.in_valid = v;
    if32.in_num   = 32'(n);
    if8.in_valid  = v;
    if8.in_num    = n;
  endtask

  task automatic drive_ready(input logic r);
    if32.res_ready = r;
    if8.res_ready  = r;
  endtask

  task automatic wait_in_ready();
    int k = 0;
    while (!(if8.in_ready && if32.in_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", 32'(k < 50), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int  lat8, lat32, t;
    bit  stable;
    logic exp_busy;
    exp_busy = (v.num > 8'd1);
    wait_in_ready();
    drive_in(1'b1, v.num);
    @(posedge clk);
    @(negedge clk);
    drive_in(1'b0, 8'hAA);
    check("busy8_after_accept",  32'(busy8),  32'(exp_busy));
    check("busy32_after_accept", 32'(busy32), 32'(exp_busy));
    check("in_ready8_after_accept", 32'(if8.in_ready), 32'd0);
    lat8 = 0; lat32 = 0; t = 1;
    while ((lat8 == 0 || lat32 == 0) && t <= 300) begin
      if (if8.res_valid  && lat8  == 0) lat8  = t;
      if (if32.res_valid && lat32 == 0) lat32 = t;
      if (lat8 == 0 || lat32 == 0) begin
        @(negedge clk);
        t++;
      end
    end
    check($sformatf("lat8_n%0d", v.num),   32'(lat8),  32'(v.lat));
    check($sformatf("lat32_n%0d", v.num),  32'(lat32), 32'(v.lat));
    check($sformatf("prime8_n%0d", v.num),  32'(if8.res_is_prime),  32'(v.prime));
    check($sformatf("prime32_n%0d", v.num), 32'(if32.res_is_prime), 32'(v.prime));
    check($sformatf("num8_n%0d", v.num),  32'(if8.res_num), 32'(v.num));
    check($sformatf("num32_n%0d", v.num), if32.res_num,     32'(v.num));
`ifdef PRIME_FACTOR_OUT_EN
    check($sformatf("factor8_n%0d", v.num),  32'(if8.res_factor), 32'(v.factor));
    check($sformatf("factor32_n%0d", v.num), if32.res_factor,     32'(v.factor));
`endif
    if (v.hold) begin
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!if8.res_valid || !if32.res_valid || if8.in_ready || if32.in_ready ||
            if8.res_num != v.num || if32.res_num != 32'(v.num) ||
            if8.res_is_prime != v.prime || if32.res_is_prime != v.prime)
          stable = 1'b0;
`ifdef PRIME_FACTOR_OUT_EN
        if (if8.res_factor != v.factor || if32.res_factor != 32'(v.factor)) stable = 1'b0;
`endif
      end
      check($sformatf("hold_stable_n%0d", v.num), 32'(stable), 32'd1);
    end
    drive_ready(1'b1);
    check("in_ready8_in_done_exit",  32'(if8.in_ready),  32'd0);
    check("in_ready32_in_done_exit", 32'(if32.in_ready), 32'd0);
    @(negedge clk);
    drive_ready(1'b0);
    check("res_valid8_after_take", 32'(if8.res_valid),  32'd0);
    check("res_valid32_after_take", 32'(if32.res_valid), 32'd0);
    check("in_ready8_after_take",  32'(if8.in_ready),   32'd1);
    check("prime8_kept_after_take", 32'(if8.res_is_prime), 32'(v.prime));
  endtask

  vec_t vecs[13];

  initial begin
    // d tested for 251 is 2,3,5,...,15 then 17 where 17*17 > 251: nine CHECK cycles.
    vecs[0]  = '{8'd17,  1'b1, 8'd17,  4,  1'b0};
    vecs[1]  = '{8'd18,  1'b0, 8'd2,   2,  1'b0};
    vecs[2]  = '{8'd0,   1'b0, 8'd0,   1,  1'b0};
    vecs[3]  = '{8'd1,   1'b0, 8'd0,   1,  1'b0};
    vecs[4]  = '{8'd2,   1'b1, 8'd2,   2,  1'b0};
    vecs[5]  = '{8'd4,   1'b0, 8'd2,   2,  1'b0};
    vecs[6]  = '{8'd25,  1'b0, 8'd5,   4,  1'b1};
    vecs[7]  = '{8'd251, 1'b1, 8'd251, 10, 1'b0};
    vecs[8]  = '{8'd255, 1'b0, 8'd3,   3,  1'b0};
    vecs[9]  = '{8'd9,   1'b0, 8'd3,   3,  1'b0};
    vecs[10] = '{8'd3,   1'b1, 8'd3,   2,  1'b0};
    vecs[11] = '{8'd49,  1'b0, 8'd7,   5,  1'b0};
    vecs[12] = '{8'd97,  1'b1, 8'd97,  7,  1'b0};

    rst = 1'b1;
    drive_in(1'b0, 8'd0);
    drive_ready(1'b0);
    repeat (3) @(negedge clk);
    check("rst_in_ready8",  32'(if8.in_ready),  32'd1);
    check("rst_res_valid8", 32'(if8.res_valid), 32'd0);
    check("rst_res_valid32", 32'(if32.res_valid), 32'd0);
    check("rst_res_num32",  if32.res_num, 32'd0);
    check("rst_is_prime8",  32'(if8.res_is_prime), 32'd0);
    check("rst_busy8",      32'(busy8),  32'd0);
    check("rst_busy32",     32'(busy32), 32'd0);
`ifdef PRIME_FACTOR_OUT_EN
    check("rst_factor32",   if32.res_factor, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready32", 32'(if32.in_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Reset in the middle of checking 251 must abandon it cleanly.
    wait_in_ready();
    drive_in(1'b1, 8'd251);
    @(posedge clk);
    @(negedge clk);
    drive_in(1'b0, 8'd0);
    repeat (2) @(negedge clk);
    check("midrst_busy8_before", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_res_valid8",  32'(if8.res_valid),  32'd0);
    check("midrst_res_valid32", 32'(if32.res_valid), 32'd0);
    check("midrst_in_ready8",   32'(if8.in_ready),   32'd1);
    check("midrst_in_ready32",  32'(if32.in_ready),  32'd1);
    check("midrst_busy32",      32'(busy32),         32'd0);
    rst = 1'b0;
    run_vec('{8'd18, 1'b0, 8'd2, 2, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
